// File: rtl/controller_multi_cycle.sv
// rtl/controller_multi_cycle.sv - multi-cycle RV32I control FSM (optional MemReady handshake via MEM_READY_EN)
module controller_multi_cycle #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
`ifdef MEM_READY_EN
    input  logic               MemReady,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [2:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    logic [STATE_W-1:0] out_state;
    logic [2:0]         alu_dec;
    logic               mem_rdy;

`ifdef MEM_READY_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    assign State = state;

    // State register; reset always wins, including over a memory wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: memory states hold until the memory is ready, unknown encodings recover to FETCH
    always_comb begin
        state_n = S_FETCH;
        case (state)
            S_FETCH:    state_n = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_n = S_MEMADR;
                    7'b0110011:             state_n = S_EXECR;
                    7'b0010011:             state_n = S_EXECI;
                    7'b1100011:             state_n = S_BRANCH;
                    7'b1101111:             state_n = S_JAL;
                    default:                state_n = S_FETCH;
                endcase
            end
            S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_n = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: state_n = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_n = S_ALUWB;
            S_EXECI:    state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BRANCH:   state_n = S_FETCH;
            S_JAL:      state_n = S_ALUWB;
            default:    state_n = S_FETCH;
        endcase
    end

    // ALU operation for R/I-type; subtract only exists for R-type with funct7[5] set
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Per-state outputs; during reset the selects show FETCH and every strobe is suppressed
    always_comb begin
        out_state  = reset ? S_FETCH : state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        case (out_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = mem_rdy;
                IRWrite   = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (op)
                    7'b0000011, 7'b0100011, 7'b0110011,
                    7'b0010011, 7'b1100011, 7'b1101111: Illegal = 1'b0;
                    default:                            Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = mem_rdy;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 3'b011;
                PCWrite = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule
